// File: rtl/seq_divider_16by8.sv
// Sequential restoring divider, N-bit dividend by M-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips iteration and completes right after accept.
module seq_divider_16by8 #(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [M-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [M-1:0] r,
    output logic         dz
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    state_t         start_target;
    logic [N-1:0]   dvd;
    logic [N-1:0]   quo;
    logic [N-1:0]   quo_nx;
    logic [M-1:0]   dvs;
    logic [M:0]     rem;
    logic [M:0]     rem_sh;
    logic [M:0]     rem_nx;
    logic [CW-1:0]  count;
    logic           ge;
    logic           last;
    logic           accept;

    assign ready  = (state == IDLE) || (state == DONE);
    assign busy   = (state == DIV);
    assign done   = (state == DONE);
    assign accept = ready && start;
    assign last   = (count == CW'(N - 1));

`ifdef DIV_ZERO_FAST_EN
    assign start_target = (b == '0) ? DONE : DIV;
`else
    assign start_target = DIV;
`endif

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem[M-1:0], dvd[N-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
        quo_nx = {quo[N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = start_target;
            end
            DIV: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                state_nx = start ? start_target : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            count <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else if (accept) begin
            dvd   <= a;
            dvs   <= b;
            rem   <= '0;
            quo   <= '0;
            count <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (b == '0) begin
                q  <= '1;
                r  <= a[M-1:0];
                dz <= 1'b1;
            end
`endif
        end else if (state == DIV) begin
            dvd   <= dvd << 1;
            rem   <= rem_nx;
            quo   <= quo_nx;
            count <= count + 1'b1;
            if (last) begin
                q  <= quo_nx;
                r  <= rem_nx[M-1:0];
                dz <= (dvs == '0);
            end
        end
    end

endmodule
